// File: rtl/spi_pkg.sv
// Shared definitions for both ends of the SPI word link.
// Holds the receiver FSM state type, the default word/field widths and the word type,
// so the transmit controller and the receiver agree on sizes.
package spi_pkg;

  localparam int unsigned WordBytesDefault = 4;
  localparam int unsigned FieldBitsDefault = 5;

  typedef logic [8*WordBytesDefault-1:0] word_t;
  typedef logic [FieldBitsDefault-1:0]   field_t;

  typedef enum logic {
    StIdle,
    StActive
  } state_e;

endpackage

// File: rtl/spi_word_receiver_if.sv
// Word delivery channel from the SPI word receiver to a consumer.
//   data       : assembled word, first received byte in the MSBs
//   dataValid  : data/fieldIndex hold a word not yet accepted
//   dataReady  : consumer takes the word when dataValid && dataReady
//   fieldIndex : index of the word within its chip-select frame
// Modports: master = word producer (receiver), slave = consumer.
interface spi_word_receiver_if #(
  parameter int unsigned WORD_BYTES = spi_pkg::WordBytesDefault,
  parameter int unsigned FIELD_BITS = spi_pkg::FieldBitsDefault
) ();

  logic [8*WORD_BYTES-1:0] data;
  logic                    dataValid;
  logic                    dataReady;
  logic [FIELD_BITS-1:0]   fieldIndex;

  modport master (
    output data,
    output dataValid,
    output fieldIndex,
    input  dataReady
  );

  modport slave (
    input  data,
    input  dataValid,
    input  fieldIndex,
    output dataReady
  );

endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous pin, followed by an edge reference flop.
//   clock, reset : system clock, asynchronous active-low reset
//   pin          : asynchronous input
//   level        : synchronized level
//   rise, fall   : single-cycle edge strobes on the synchronized level
// ResetValue is the idle level of the pin, so leaving reset creates no false edge.
module spi_pin_sync #(
  parameter bit ResetValue = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0],[1] are the synchronizer stages, [2] holds the previous synchronized level.
  logic [2:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= {3{ResetValue}};
    end else begin
      sync_q <= {sync_q[1:0], pin};
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_word_receiver.sv
// Mode-0 SPI slave, oversampled by the system clock. Shifts in MSB-first bits, groups
// every 8*WORD_BYTES bits into a big-endian word tagged with its index within the
// chip-select frame, and offers it on a valid/ready channel.
//   clock, reset     : system clock, asynchronous active-low reset
//   sclk, mosi, ssN  : asynchronous SPI pins (ssN active-low)
//   word_bus         : data / dataValid / dataReady / fieldIndex channel
//   frameError       : pulse, frame closed on a non-word boundary
//   overrun          : pulse, completed word dropped because the holding register was full
module spi_word_receiver
  import spi_pkg::*;
#(
  parameter int unsigned WORD_BYTES = WordBytesDefault,
  parameter int unsigned FIELD_BITS = FieldBitsDefault
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sclk,
  input  logic                       mosi,
  input  logic                       ssN,
  spi_word_receiver_if.master        word_bus,
  output logic                       frameError,
  output logic                       overrun
);

  localparam int unsigned WordBits = 8 * WORD_BYTES;
  localparam int unsigned CntBits  = $clog2(WordBits);
  localparam logic [CntBits-1:0] LastBit = CntBits'(WordBits - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic ss_lvl, ss_rise, ss_fall;

  spi_pin_sync #(.ResetValue(1'b0)) u_sync_sclk (
    .clock(clock), .reset(reset), .pin(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.ResetValue(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .pin(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_pin_sync #(.ResetValue(1'b1)) u_sync_ss (
    .clock(clock), .reset(reset), .pin(ssN),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, sclk_fall, mosi_rise, mosi_fall};

  state_e                state_q;
  logic [CntBits-1:0]    bit_cnt_q;
  logic [WordBits-1:0]   shift_q;
  logic [FIELD_BITS-1:0] field_cnt_q;
  logic                  done_q;        // shift_q holds a complete word this cycle
  logic [FIELD_BITS-1:0] done_field_q;  // index captured when that word completed
  logic [WordBits-1:0]   data_q;
  logic                  valid_q;
  logic [FIELD_BITS-1:0] index_q;
  logic                  frame_err_q;
  logic                  overrun_q;
  logic [1:0]            settle_q;      // synchronizers have seen the real pins
  logic                  armed_q;       // ssN observed high since reset

  logic last_bit;
  logic partial_at_end;
  logic accept;

  assign last_bit = (bit_cnt_q == LastBit);
  // Bit count as it will stand after this cycle's shift; a word finishing on the
  // same cycle as the ssN rise counts as complete.
  assign partial_at_end = sclk_rise ? !last_bit : (bit_cnt_q != '0);
  assign accept = valid_q && word_bus.dataReady;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      field_cnt_q  <= '0;
      done_q       <= 1'b0;
      done_field_q <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      index_q      <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      settle_q     <= '0;
      armed_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
      settle_q    <= {settle_q[0], 1'b1};

      // A chip select already low at reset release must go high before a frame counts.
      if (settle_q[1] && ss_lvl) begin
        armed_q <= 1'b1;
      end

      if (accept) begin
        valid_q <= 1'b0;
      end

      if (done_q) begin
        if (!valid_q || word_bus.dataReady) begin
          data_q  <= shift_q;
          index_q <= done_field_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      case (state_q)
        StIdle: begin
          if (ss_fall && armed_q) begin
            state_q     <= StActive;
            bit_cnt_q   <= '0;
            field_cnt_q <= '0;
          end
        end
        StActive: begin
          if (sclk_rise) begin
            shift_q   <= {shift_q[WordBits-2:0], mosi_lvl};
            bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
            if (last_bit) begin
              done_q       <= 1'b1;
              done_field_q <= field_cnt_q;
              field_cnt_q  <= field_cnt_q + 1'b1;
            end
          end
          if (ss_rise) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            field_cnt_q <= '0;
            frame_err_q <= partial_at_end;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign word_bus.data       = data_q;
  assign word_bus.dataValid  = valid_q;
  assign word_bus.fieldIndex = index_q;
  assign frameError          = frame_err_q;
  assign overrun             = overrun_q;

endmodule

// File: doc/spi_word_receiver.md
# spi_word_receiver

Receiving end of the SPI word link driven by the SPI transmit controller. It acts as a mode-0 SPI slave oversampled by the system clock and shifts in MSB-first bytes. It reassembles every four bytes into a big-endian 32-bit word, tagged with its field index within the current chip-select frame, and delivers the word over a valid/ready handshake to downstream sensor-data consumers.

## Interface
Parameters:
- WORD_BYTES, 4, bytes per assembled word (data width = 8*WORD_BYTES)
- FIELD_BITS, 5, width of the field index counter

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- sclk  input  1  SPI serial clock from master, asynchronous to clock
- mosi  input  1  SPI data from master, asynchronous
- ssN  input  1  SPI chip select, active-low, asynchronous
- data  output  8*WORD_BYTES  assembled word, first received byte in MSBs
- dataValid  output  1  data/fieldIndex hold a word not yet accepted
- dataReady  input  1  consumer accepts word when dataValid && dataReady
- fieldIndex  output  FIELD_BITS  index of word within current frame
- frameError  output  1  one-cycle pulse: frame ended on a non-word boundary
- overrun  output  1  one-cycle pulse: completed word dropped, holding register full

## Operation
- sclk, mosi, ssN each pass through a 2-FF synchronizer. Rising/falling edges of sclk and ssN are detected on the synchronized versions.
- States: IDLE, ACTIVE.
  - IDLE: bit count, byte count and field counter are 0, and shift input is ignored. A falling edge on synchronized ssN -> ACTIVE.
  - ACTIVE: each synchronized sclk rising edge shifts mosi into the LSB of the word shift register and increments a bit count of width log2(8*WORD_BYTES).
  - ACTIVE: when the bit count wraps (8*WORD_BYTES bits received), the word is complete.
- Word complete, holding register empty or being accepted in the same cycle:
  - load data and fieldIndex, set dataValid;
  - field counter increments modulo 2^FIELD_BITS (31 -> 0).
- Word complete, holding register full and not accepted this cycle:
  - word dropped, overrun pulses;
  - field counter still increments, so indices stay aligned to the master's fields.
- dataValid clears on the cycle after dataValid && dataReady, unless a new word loads in that same cycle.
- Rising edge of synchronized ssN in ACTIVE -> IDLE:
  - if bit count is nonzero, frameError pulses and the partial word is discarded;
  - bit count and field counter reset to 0;
  - the holding register is untouched, so a pending word stays valid.
- sclk edges while ssN is synchronized-high are ignored.
- Asynchronous reset mid-frame: return to IDLE immediately and drop the partial word. The next frame must start with a fresh ssN falling edge; if ssN is already low when reset releases, the block waits for ssN to go high and then low again.

## Timing
- Reset values:
  - data = 0, dataValid = 0, fieldIndex = 0, frameError = 0, overrun = 0;
  - state IDLE;
  - synchronizer flops reset to sclk=0, mosi=0, ssN=1.
- sclk high and low times must each be at least 3 clock periods (f_sclk ≤ f_clock/6).
- ssN falling edge to first sclk rising edge must be at least 3 clock periods.
- Pin sclk rising edge to bit shifted: 3 clocks (2 sync stages + edge register).
- Last-bit sclk edge to dataValid high: 4 clocks.
- Handshake:
  - data/fieldIndex must stay stable while dataValid is high;
  - a word can be accepted on its first valid cycle;
  - throughput is one word per 8*WORD_BYTES sclk periods.
- Word completion coinciding with the ssN rising edge: the word completes first, and no frameError.

## Structure
- Shared package spi_pkg holds:
  - state enum (IDLE, ACTIVE);
  - WORD_BYTES and FIELD_BITS defaults;
  - the word type.
- The SPI transmit controller imports the same package so both ends agree on word and field widths.
- One sub-module, spi_pin_sync:
  - parameterised 2-FF synchronizer with a registered edge detect;
  - outputs level, rise and fall;
  - instantiated three times.

## Test plan
- Single frame, bytes DE AD BE EF, dataReady=1 -> one dataValid cycle, data=0xDEADBEEF, fieldIndex=0, no error pulses.
- Frame of 3 words 0x00000001, 0x80000000, 0x12345678 -> fieldIndex 0,1,2 in order; next frame restarts at 0.
- dataReady=0 over 2 words -> first word held stable, second word drops with one overrun pulse; after dataReady=1, next word has fieldIndex=2.
- ssN rises after 13 bits -> frameError pulses once, no dataValid; next frame AB CD EF 01 -> data=0xABCDEF01, fieldIndex=0.
- 33 words in one frame -> fieldIndex wraps 31 -> 0 on word 33.
- reset asserted mid-word with ssN low -> outputs at reset values; bits clocked before ssN toggles high then low are ignored; the following frame decodes correctly.
